// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: PC control, instruction-memory read port and decoder handshake.
// master = instr_fetch side, slave = surrounding pc block / imem / decoder.
interface instr_fetch_if #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 32
);
  logic                   start;
  logic                   halt;
  logic                   redirect;
  logic [PC_WIDTH-1:0]    redirect_pc;
  logic [PC_WIDTH-1:0]    PC;
  logic                   PC_enable;
  logic                   PC_load;
  logic [PC_WIDTH-1:0]    PC_load_val;
  logic                   imem_en;
  logic [PC_WIDTH-1:0]    imem_addr;
  logic [INSTR_WIDTH-1:0] imem_rdata;
  logic                   instr_valid;
  logic                   instr_ready;
  logic [INSTR_WIDTH-1:0] instr;
  logic [PC_WIDTH-1:0]    instr_pc;
  logic                   busy;

  modport master (
    input  start, halt, redirect, redirect_pc, PC, imem_rdata, instr_ready,
    output PC_enable, PC_load, PC_load_val, imem_en, imem_addr,
           instr_valid, instr, instr_pc, busy
  );

  modport slave (
    output start, halt, redirect, redirect_pc, PC, imem_rdata, instr_ready,
    input  PC_enable, PC_load, PC_load_val, imem_en, imem_addr,
           instr_valid, instr, instr_pc, busy
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues reads at the current PC, buffers returned words
// in a small queue and hands them to decode; redirect/halt flush queue and in-flight read.
module instr_fetch #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 32,
  parameter int FQ_DEPTH    = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  instr_fetch_if.master  fif
);
  localparam int PTR_W = $clog2(FQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic                   inflight_q, inflight_d;
  logic [PC_WIDTH-1:0]    inflight_pc_q, inflight_pc_d;

  logic [INSTR_WIDTH-1:0] fq_instr [FQ_DEPTH];
  logic [PC_WIDTH-1:0]    fq_pc    [FQ_DEPTH];

  logic                   run;
  logic                   flush;
  logic                   pop;
  logic                   push;
  logic                   issue;
  logic                   head_valid;
  logic [CNT_W:0]         credit;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: halt beats start, start is a no-op once running
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fif.start && !fif.halt) state_d = RUN;
      RUN:     if (fif.halt)               state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    run        = (state_q == RUN);
    head_valid = (count_q != '0);
    flush      = fif.halt || fif.redirect;
    pop        = head_valid && fif.instr_ready;
    // Credit counts the in-flight word so the queue can never overflow
    credit     = (CNT_W+1)'(count_q) + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
    issue      = run && !flush && (credit < (CNT_W+1)'(FQ_DEPTH));
    push       = inflight_q && !flush;

    fif.busy        = run;
    fif.imem_en     = issue;
    fif.imem_addr   = fif.PC;
    fif.PC_enable   = issue;
    fif.PC_load     = fif.redirect;
    fif.PC_load_val = fif.redirect_pc;
    fif.instr_valid = head_valid;
    fif.instr       = head_valid ? fq_instr[rd_ptr_q] : '0;
    fif.instr_pc    = head_valid ? fq_pc[rd_ptr_q]    : '0;
  end

  // Queue bookkeeping and in-flight tracking
  always_comb begin
    count_d       = count_q + CNT_W'(push) - CNT_W'(pop);
    rd_ptr_d      = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d      = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    inflight_d    = issue;
    inflight_pc_d = issue ? fif.PC : inflight_pc_q;
    if (flush) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  // Storage needs no reset: entries are only visible while count is nonzero
  always_ff @(posedge clk) begin
    if (push) begin
      fq_instr[wr_ptr_q] <= fif.imem_rdata;
      fq_pc[wr_ptr_q]    <= inflight_pc_q;
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a pc-block model, a one-cycle imem model
// and an in-order scoreboard of the words the decoder should receive.
module tb_instr_fetch;
  localparam int PW = 8;
  localparam int IW = 32;
  localparam int FD = 2;

  typedef struct {
    logic [IW-1:0] instr;
    logic [PW-1:0] pc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic pc_set;
  logic [PW-1:0] pc_set_val;
  logic [PW-1:0] pc_q;

  int passed  = 0;
  int total   = 0;
  int pop_cnt = 0;
  int p0;
  exp_t exp_q[$];

  instr_fetch_if #(.PC_WIDTH(PW), .INSTR_WIDTH(IW)) bus ();

  instr_fetch #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .FQ_DEPTH(FD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fif   (bus)
  );

  always #5 clk = ~clk;

  // pc block model
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)              pc_q <= '0;
    else if (pc_set)         pc_q <= pc_set_val;
    else if (bus.PC_load)    pc_q <= bus.PC_load_val;
    else if (bus.PC_enable)  pc_q <= pc_q + 8'd1;
  end
  assign bus.PC = pc_q;

  // instruction memory: mem[a] = 0xA000_0000 + a, one-cycle read latency
  always @(posedge clk) begin
    if (bus.imem_en) bus.imem_rdata <= 32'hA000_0000 + 32'(bus.imem_addr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp_v);
  endtask

  task automatic load_exp(input logic [PW-1:0] pc0, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.pc    = pc0 + PW'(i);
      e.instr = 32'hA000_0000 + 32'(e.pc);
      exp_q.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Decoder-side monitor: every accepted word must be the next expected one
  always @(negedge clk) begin
    if (rst_n && bus.instr_valid && bus.instr_ready) begin
      exp_t e;
      pop_cnt++;
      total++;
      assert (exp_q.size() != 0) begin
        passed++;
        e = exp_q.pop_front();
        $display("xfer pc=0x%02h instr=0x%08h", bus.instr_pc, bus.instr);
        check("sb_instr", bus.instr, e.instr);
        check("sb_pc", 32'(bus.instr_pc), 32'(e.pc));
      end else $error("FAIL sb_underflow: observed word pc=0x%0h required none", bus.instr_pc);
    end
  end

  initial begin
    rst_n = 1'b0; pc_set = 1'b0; pc_set_val = '0;
    bus.start = 1'b0; bus.halt = 1'b0; bus.instr_ready = 1'b0;
    bus.redirect = 1'b1; bus.redirect_pc = 8'h33;
    #1;
    // Reset state; PC_load passes through even in reset
    check("rst_valid",   32'(bus.instr_valid), 32'd0);
    check("rst_instr",   bus.instr, 32'd0);
    check("rst_instr_pc",32'(bus.instr_pc), 32'd0);
    check("rst_pc_en",   32'(bus.PC_enable), 32'd0);
    check("rst_imem_en", 32'(bus.imem_en), 32'd0);
    check("rst_busy",    32'(bus.busy), 32'd0);
    check("rst_pc_load", 32'(bus.PC_load), 32'd1);
    check("rst_pc_lval", 32'(bus.PC_load_val), 32'h33);
    bus.redirect = 1'b0; bus.redirect_pc = '0;
    step(); step();
    rst_n = 1'b1;
    step();

    // Streaming from PC 0
    load_exp(8'h00, 64);
    bus.instr_ready = 1'b1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    @(negedge clk);
    check("start_imem_en", 32'(bus.imem_en), 32'd1);
    check("start_busy",    32'(bus.busy), 32'd1);
    check("start_valid0",  32'(bus.instr_valid), 32'd0);
    step(); @(negedge clk);
    check("start_valid1",  32'(bus.instr_valid), 32'd0);
    step(); @(negedge clk);
    check("start_valid2",  32'(bus.instr_valid), 32'd1);
    check("first_pc",      32'(bus.instr_pc), 32'd0);
    repeat (8) begin
      step(); @(negedge clk);
      check("stream_pc_en", 32'(bus.PC_enable), 32'd1);
    end
    step();
    check("stream_pops", 32'(pop_cnt), 32'd9);

    // Backpressure: head held stable, queue fills to FQ_DEPTH, fetch stops
    bus.instr_ready = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("bp_valid",    32'(bus.instr_valid), 32'd1);
      check("bp_head_pc",  32'(bus.instr_pc), 32'(exp_q[0].pc));
      step();
    end
    @(negedge clk);
    check("bp_imem_en", 32'(bus.imem_en), 32'd0);
    check("bp_pc_en",   32'(bus.PC_enable), 32'd0);
    check("bp_issued",  32'(pc_q), 32'(exp_q[0].pc + 8'(FD)));
    step();
    bus.instr_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      step();
    end
    check("bp_release_pops", 32'(pop_cnt), 32'd13);

    // Redirect with queue + in-flight at capacity
    bus.instr_ready = 1'b0;
    repeat (3) step();
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
    bus.redirect = 1'b1; bus.redirect_pc = 8'h40;
    load_exp(8'h40, 64);
    @(negedge clk);
    check("rd_pc_load",  32'(bus.PC_load), 32'd1);
    check("rd_pc_lval",  32'(bus.PC_load_val), 32'h40);
    check("rd_no_issue", 32'(bus.imem_en), 32'd0);
    check("rd_valid",    32'(bus.instr_valid), 32'd1);
    step();
    bus.redirect = 1'b0; bus.instr_ready = 1'b1;
    @(negedge clk);
    check("rd1_pc_load", 32'(bus.PC_load), 32'd0);
    check("rd1_valid",   32'(bus.instr_valid), 32'd0);
    check("rd1_imem_en", 32'(bus.imem_en), 32'd1);
    check("rd1_addr",    32'(bus.imem_addr), 32'h40);
    step(); @(negedge clk);
    check("rd2_valid",   32'(bus.instr_valid), 32'd0);
    step(); @(negedge clk);
    check("rd3_valid",   32'(bus.instr_valid), 32'd1);
    check("rd3_pc",      32'(bus.instr_pc), 32'h40);
    repeat (4) step();

    // halt + start together in RUN, then resume at 0xFE to exercise wrap
    bus.halt = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    check("halt_imem_en", 32'(bus.imem_en), 32'd0);
    check("halt_pc_en",   32'(bus.PC_enable), 32'd0);
    step();
    bus.halt = 1'b0; bus.start = 1'b0;
    pc_set = 1'b1; pc_set_val = 8'hFE;
    exp_q.delete();
    @(negedge clk);
    check("halt_busy",  32'(bus.busy), 32'd0);
    check("halt_valid", 32'(bus.instr_valid), 32'd0);
    step();
    pc_set = 1'b0;
    load_exp(8'hFE, 64);
    repeat (3) begin
      @(negedge clk);
      check("idle_busy",    32'(bus.busy), 32'd0);
      check("idle_imem_en", 32'(bus.imem_en), 32'd0);
      step();
    end
    p0 = pop_cnt;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    @(negedge clk);
    check("resume_addr", 32'(bus.imem_addr), 32'hFE);
    check("resume_en",   32'(bus.imem_en), 32'd1);
    step(); step(); @(negedge clk);
    check("wrap_first_pc", 32'(bus.instr_pc), 32'hFE);
    repeat (4) begin
      step(); @(negedge clk);
    end
    step();
    check("wrap_pops", 32'(pop_cnt - p0), 32'd5);

    // Asynchronous reset between edges while streaming
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid",   32'(bus.instr_valid), 32'd0);
    check("arst_imem_en", 32'(bus.imem_en), 32'd0);
    check("arst_pc_en",   32'(bus.PC_enable), 32'd0);
    check("arst_busy",    32'(bus.busy), 32'd0);
    exp_q.delete();
    step(); step();
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("post_rst_valid",   32'(bus.instr_valid), 32'd0);
      check("post_rst_imem_en", 32'(bus.imem_en), 32'd0);
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
